// File: rtl/dmem_lsu.sv
// Load/store unit: turns byte-addressed CPU requests into word-indexed memory
// accesses, with read-modify-write for sub-word stores and lane extraction for loads.
module dmem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    // state    | meaning
    // IDLE     | ready for a request       ERR      | error response
    // LD_ISSUE | load read strobe          LD_CAP   | capture/extend load lane
    // ST_RD    | RMW read strobe           ST_MERGE | insert store lane(s)
    // ST_WR    | write strobe              RESP     | normal response
    typedef enum logic [2:0] {
        IDLE, ERR, LD_ISSUE, LD_CAP, ST_RD, ST_MERGE, ST_WR, RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                  state;
    state_t                  state_nxt;
    logic                    req_err;
    logic                    lat_we;
    logic [1:0]              lat_size;
    logic                    lat_uns;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [WORD_WIDTH-1:0]   lat_wdata;
    logic [WORD_WIDTH-1:0]   result;
    logic [WORD_WIDTH-1:0]   merge;
    logic [WORD_WIDTH-1:0]   load_val;
    logic [WORD_WIDTH-1:0]   merge_val;
    logic [4:0]              byte_sh;
    logic [4:0]              half_sh;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;

    assign req_err = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)               state_nxt = ERR;
                    else if (!req_we)          state_nxt = LD_ISSUE;
                    else if (req_size == SZ_WORD) state_nxt = ST_WR;
                    else                       state_nxt = ST_RD;
                end
            end
            ERR:      state_nxt = IDLE;
            LD_ISSUE: state_nxt = LD_CAP;
            LD_CAP:   state_nxt = RESP;
            ST_RD:    state_nxt = ST_MERGE;
            ST_MERGE: state_nxt = ST_WR;
            ST_WR:    state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Lane positions come only from the latched address, never from req_*.
    assign byte_sh = {lat_addr[1:0], 3'b000};
    assign half_sh = {lat_addr[1], 4'b0000};
    assign rd_byte = mem_rdata[byte_sh +: 8];
    assign rd_half = mem_rdata[half_sh +: 16];

    always_comb begin
        load_val = mem_rdata;
        if (lat_size == SZ_BYTE)
            load_val = {{24{!lat_uns && rd_byte[7]}}, rd_byte};
        else if (lat_size == SZ_HALF)
            load_val = {{16{!lat_uns && rd_half[15]}}, rd_half};
    end

    always_comb begin
        merge_val = mem_rdata;
        if (lat_size == SZ_BYTE)
            merge_val[byte_sh +: 8] = lat_wdata[7:0];
        else
            merge_val[half_sh +: 16] = lat_wdata[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            result    <= '0;
            merge     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state == LD_CAP)   result <= load_val;
            if (state == ST_MERGE) merge  <= merge_val;
        end
    end

    // Strobes and responses are masked while rst is high so a reset cycle
    // never touches memory or reports completion.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = !rst && (state == ERR || state == RESP);
        resp_err   = !rst && (state == ERR);
        resp_rdata = (!rst && state == RESP && !lat_we) ? result : '0;
        mem_read   = !rst && (state == LD_ISSUE || state == ST_RD);
        mem_write  = !rst && (state == ST_WR);
        mem_addr   = {2'b00, lat_addr[ADDR_WIDTH-1:2]};
        mem_wdata  = '0;
        if (!rst && state == ST_WR)
            mem_wdata = (lat_size == SZ_WORD) ? lat_wdata : merge;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: small word memory model plus a response scoreboard.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    dmem_lsu #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } exp_t;
    typedef struct { logic err; logic [31:0] rdata; int cyc; } got_t;

    exp_t        sb[$];
    got_t        got[$];
    logic [31:0] mem [0:15];
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap = 0;
    int          resp_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read) begin
            rd_cnt    <= rd_cnt + 1;
            mem_rdata <= mem[mem_addr[3:0]];
        end
        if (mem_write) begin
            wr_cnt     <= wr_cnt + 1;
            mem[mem_addr[3:0]] <= mem_wdata;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (mem_read && mem_write) overlap <= overlap + 1;
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            got.push_back('{err: resp_err, rdata: resp_rdata, cyc: cyc});
            resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_resp(input string tag);
        int   n = 0;
        exp_t e;
        got_t g;
        while (got.size() == 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_resp_seen"}, 32'(got.size() != 0), 32'd1);
        if (got.size() != 0 && sb.size() != 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            chk({tag, "_err"}, 32'(g.err), 32'(e.err));
            chk({tag, "_rdata"}, g.rdata, e.rdata);
            chk({tag, "_latency"}, 32'(g.cyc - e.acc), 32'(e.lat));
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
        end
    endtask

    // Drives one request, records the expected response at accept, then checks it.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic err, input logic [31:0] rdata, input int lat);
        wait_ready(tag);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        sb.push_back('{err: err, rdata: rdata, acc: cyc, lat: lat});
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(tag);
    endtask

    initial begin
        int rd0, wr0, rc0;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, rc0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        wr0 = wr_cnt;
        do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        chk("st_word_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("st_word_waddr", last_waddr, 32'd4);
        chk("st_word_wdata", last_wdata, 32'hDEADBEEF);
        do_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3);

        do_req("st_word2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, 2);
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, 1'b0, 32'h0, 4);
        chk("st_byte_rd_count", 32'(rd_cnt - rd0), 32'd1);
        chk("st_byte_wr_count", 32'(wr_cnt - wr0), 32'd1);
        chk("st_byte_mem", mem[4], 32'hA5223344);
        do_req("ld_byte_s13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFA5, 3);
        do_req("ld_byte_u13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000A5, 3);
        do_req("ld_byte_s10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00000044, 3);
        do_req("ld_byte_u11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000033, 3);

        do_req("st_half", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 1'b0, 32'h0, 4);
        chk("st_half_mem", mem[4], 32'h80013344);
        do_req("ld_half_s12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF8001, 3);
        do_req("ld_half_u10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h00003344, 3);

        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req("err_ld_word11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1);
        do_req("err_st_half13", 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, 1'b1, 32'h0, 1);
        do_req("err_size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1);
        chk("err_no_read", 32'(rd_cnt - rd0), 32'd0);
        chk("err_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("err_mem_intact", mem[4], 32'h80013344);

        // Two loads with req_valid held high throughout.
        wait_ready("b2b");
        rc0 = resp_cnt;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = '0; req_valid = 1'b1;
        sb.push_back('{err: 1'b0, rdata: 32'h80013344, acc: cyc, lat: 3});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            if (k < 4) chk($sformatf("b2b_busy_k%0d", k), 32'(req_ready), 32'd0);
        end
        chk("b2b_second_ready", 32'(req_ready), 32'd1);
        sb.push_back('{err: 1'b0, rdata: 32'h80013344, acc: cyc, lat: 3});
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("b2b_first");
        wait_resp("b2b_second");
        repeat (4) @(negedge clk);
        #1;
        chk("b2b_resp_count", 32'(resp_cnt - rc0), 32'd2);

        // Reset while a byte store sits in ST_MERGE.
        wait_ready("rst_merge");
        wr0 = wr_cnt; rc0 = resp_cnt;
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        chk("rst_merge_rd_strobe", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_merge_no_write", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_merge_ready", 32'(req_ready), 32'd1);
        repeat (6) @(negedge clk);
        #1;
        chk("rst_merge_wr_count", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_merge_resp_count", 32'(resp_cnt - rc0), 32'd0);
        chk("rst_merge_mem", mem[4], 32'h80013344);

        // Reset landing in the ST_WR cycle of a word store must mask the strobe.
        wait_ready("rst_wr");
        wr0 = wr_cnt; rc0 = resp_cnt;
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wr_strobe_masked", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_wr_wr_count", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_wr_resp_count", 32'(resp_cnt - rc0), 32'd0);
        chk("rst_wr_mem", mem[4], 32'h80013344);

        do_req("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80013344, 3);
        chk("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
